// File: rtl/block_spi_slave_n.sv
// rtl/block_spi_slave_n.sv - parametrised SPI slave: all modes, bit order, TX holding register, RX handshake
// Optional RX FIFO: define SPI_SLAVE_RX_FIFO_EN (FIFO_DEPTH entries); default is a single RX holding register.
module block_spi_slave_n #(
  parameter int                DATA_W     = 8,
  parameter bit                CPOL       = 1'b0,
  parameter bit                CPHA       = 1'b0,
  parameter bit                MSB_FIRST  = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD  = '1,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SPI_SCK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  input  logic              data_ack,
  output logic              rx_overrun,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [7:0]        frame_words,
  output logic              frame_end,
  output logic              frame_partial
);

  localparam int CNT_W = 6;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  state_t state_q, state_d;

  logic [2:0]        sck_sync_q, cs_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              sck_lead, sck_trail, sample_edge, shift_edge;
  logic              cs_fall, cs_rise, mosi_s;

  logic              frame_start, frame_stop, sample_en, shift_en, word_done, load_tx;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q, rx_next;
  logic              push_q;
  logic [DATA_W-1:0] push_data_q;
  logic [DATA_W-1:0] tx_shift_q, tx_hold_q;
  logic              tx_full_q, tx_underrun_q, miso_q, tx_bit;
  logic [7:0]        frame_words_q;
  logic              frame_end_q, frame_partial_q;

  // CS synchroniser resets low so a frame already in progress never looks like a fresh CS fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync_q  <= {3{CPOL}};
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], SPI_SCK};
      cs_sync_q   <= {cs_sync_q[1:0], SPI_CS};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
    end
  end

  assign sck_lead    = (sck_sync_q[2] == CPOL) && (sck_sync_q[1] != CPOL);
  assign sck_trail   = (sck_sync_q[2] != CPOL) && (sck_sync_q[1] == CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead : sck_trail;
  assign cs_fall     = cs_sync_q[2] && !cs_sync_q[1];
  assign cs_rise     = !cs_sync_q[2] && cs_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A shift edge with the bit counter at 0 keeps the freshly loaded bit 0 on MISO.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d    = ST_IDLE;
          frame_stop = 1'b1;
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge && (bit_cnt_q != '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign word_done = sample_en && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign load_tx   = frame_start || word_done;

  always_comb begin
    if (MSB_FIRST) begin
      rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};
    end else begin
      rx_next = {mosi_s, rx_shift_q[DATA_W-1:1]};
    end
  end

  assign tx_bit = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q       <= '0;
      rx_shift_q      <= '0;
      push_q          <= 1'b0;
      push_data_q     <= '0;
      tx_shift_q      <= '0;
      tx_hold_q       <= '0;
      tx_full_q       <= 1'b0;
      tx_underrun_q   <= 1'b0;
      miso_q          <= 1'b0;
      frame_words_q   <= '0;
      frame_end_q     <= 1'b0;
      frame_partial_q <= 1'b0;
    end else begin
      push_q        <= word_done;
      push_data_q   <= rx_next;
      tx_underrun_q <= 1'b0;
      frame_end_q   <= frame_stop;
      miso_q        <= (state_q == ST_ACTIVE) ? tx_bit : 1'b0;

      if (frame_start || frame_stop) begin
        bit_cnt_q <= '0;
      end else if (sample_en) begin
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
      end

      if (sample_en) begin
        rx_shift_q <= rx_next;
      end

      if (frame_start) begin
        frame_words_q <= '0;
      end else if (word_done && frame_words_q != 8'hFF) begin
        frame_words_q <= frame_words_q + 8'd1;
      end

      if (frame_stop) begin
        frame_partial_q <= (bit_cnt_q != '0);
      end

      if (load_tx) begin
        tx_shift_q    <= tx_full_q ? tx_hold_q : IDLE_WORD;
        tx_underrun_q <= !tx_full_q;
      end else if (shift_en) begin
        tx_shift_q <= MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);
      end

      // A write landing in the same cycle as an empty-register load refills the holding register.
      if (tx_full_q) begin
        tx_full_q <= !load_tx;
      end else if (tx_valid) begin
        tx_full_q <= 1'b1;
        tx_hold_q <= tx_data;
      end
    end
  end

  assign SPI_MISO      = miso_q;
  assign tx_ready      = !tx_full_q;
  assign tx_underrun   = tx_underrun_q;
  assign frame_words   = frame_words_q;
  assign frame_end     = frame_end_q;
  assign frame_partial = frame_partial_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic              rx_overrun_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = data_ack && !fifo_empty;
  assign fifo_push  = push_q && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rx_overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      rx_overrun_q <= push_q && !fifo_push;
      if (fifo_push) begin
        fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
        wr_ptr_q                     <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign data_out   = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign data_ready = !fifo_empty;
  assign rx_overrun = rx_overrun_q;
`else
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, rx_overrun_q;
  logic              unused_fifo_depth;

  assign unused_fifo_depth = (FIFO_DEPTH > 0);

  // An ack in the same cycle as a completion frees the register for the new word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;
      if (push_q) begin
        if (rx_valid_q && !data_ack) begin
          rx_overrun_q <= 1'b1;
        end else begin
          rx_data_q  <= push_data_q;
          rx_valid_q <= 1'b1;
        end
      end else if (data_ack) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign data_out   = rx_data_q;
  assign data_ready = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_block_spi_slave_n.sv
// tb/tb_block_spi_slave_n.sv - self-checking bench for block_spi_slave_n
// Instances 0..3 are DATA_W=8 MSB-first in SPI modes 0..3; instance 4 is DATA_W=12 LSB-first mode 0.
module tb_block_spi_slave_n;

  localparam int H = 8;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int RX_CAP = 4;
  localparam int OVR_WORDS = 6;
`else
  localparam int RX_CAP = 1;
  localparam int OVR_WORDS = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic sck [5];
  logic cs [5];
  logic mosi [5];
  logic miso [5];
  logic rdy [5];
  logic ack [5] = '{default: 1'b0};
  logic ovr [5];
  logic txv [5];
  logic txr [5];
  logic und [5];
  logic fend [5];
  logic fpart [5];
  logic [7:0] fw [5];
  logic [7:0] dout8 [4];
  logic [7:0] txd8 [4];
  logic [11:0] dout12, txd12;
  logic [11:0] dout [5];

  int n_checks = 0;
  int n_fail = 0;
  logic auto_ack = 1'b1;

  int und_cnt [5] = '{default: 0};
  int ovr_cnt [5] = '{default: 0};
  int fend_cnt [5] = '{default: 0};
  logic last_part [5] = '{default: 1'b0};
  logic [11:0] got_q [$];
  int got_idx [$];
  int und_snap;

  logic [11:0] send_w [8];
  logic [11:0] miso_w [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    block_spi_slave_n #(
      .DATA_W(8), .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .MSB_FIRST(1'b1),
      .IDLE_WORD(8'hFF), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .SPI_SCK(sck[g]), .SPI_CS(cs[g]), .SPI_MOSI(mosi[g]),
      .SPI_MISO(miso[g]), .data_out(dout8[g]), .data_ready(rdy[g]), .data_ack(ack[g]),
      .rx_overrun(ovr[g]), .tx_data(txd8[g]), .tx_valid(txv[g]), .tx_ready(txr[g]),
      .tx_underrun(und[g]), .frame_words(fw[g]), .frame_end(fend[g]), .frame_partial(fpart[g])
    );
    assign dout[g] = {4'b0, dout8[g]};
  end

  block_spi_slave_n #(
    .DATA_W(12), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .IDLE_WORD(12'hFFF), .FIFO_DEPTH(4)
  ) u_dut_w12 (
    .clk(clk), .rst_n(rst_n), .SPI_SCK(sck[4]), .SPI_CS(cs[4]), .SPI_MOSI(mosi[4]),
    .SPI_MISO(miso[4]), .data_out(dout12), .data_ready(rdy[4]), .data_ack(ack[4]),
    .rx_overrun(ovr[4]), .tx_data(txd12), .tx_valid(txv[4]), .tx_ready(txr[4]),
    .tx_underrun(und[4]), .frame_words(fw[4]), .frame_end(fend[4]), .frame_partial(fpart[4])
  );
  assign dout[4] = dout12;

  // Pulse counters and an auto-acking consumer, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (und[i] === 1'b1) und_cnt[i]++;
      if (ovr[i] === 1'b1) ovr_cnt[i]++;
      if (fend[i] === 1'b1) begin
        fend_cnt[i]++;
        last_part[i] = fpart[i];
      end
      if (ack[i]) begin
        ack[i] = 1'b0;
      end else if (rdy[i] === 1'b1 && auto_ack) begin
        got_q.push_back(dout[i]);
        got_idx.push_back(i);
        ack[i] = 1'b1;
      end
    end
  end

  function automatic int width_of(input int idx);
    return (idx == 4) ? 12 : 8;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input int idx, input logic [11:0] word);
    int t;
    t = 0;
    while (txr[idx] !== 1'b1 && t < 200) begin
      wait_clk(1);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_push_timeout idx=%0d tx_ready=%b required 1", idx, txr[idx]);
    end
    if (idx == 4) txd12 = word;
    else txd8[idx] = word[7:0];
    txv[idx] = 1'b1;
    wait_clk(1);
    txv[idx] = 1'b0;
  endtask

  task automatic cs_low(input int idx);
    cs[idx] = 1'b0;
    wait_clk(10);
  endtask

  task automatic cs_high(input int idx);
    wait_clk(H);
    cs[idx] = 1'b1;
    wait_clk(12);
  endtask

  // Master bit engine: bit k of the frame belongs to word k/W; MISO is sampled on the sample edge.
  task automatic spi_bits(input int idx, input int k0, input int k1);
    int w, wi, bi, pos;
    bit cpol, cpha, msb;
    logic b, r;
    w = width_of(idx);
    cpol = (idx == 2 || idx == 3);
    cpha = (idx == 1 || idx == 3);
    msb = (idx != 4);
    for (int k = k0; k < k1; k++) begin
      wi = k / w;
      bi = k % w;
      pos = msb ? (w - 1 - bi) : bi;
      b = send_w[wi][pos];
      if (k == k1 - 1) und_snap = und_cnt[idx];
      if (!cpha) begin
        mosi[idx] = b;
        wait_clk(H);
        r = miso[idx];
        sck[idx] = ~cpol;
        wait_clk(H);
        sck[idx] = cpol;
      end else begin
        sck[idx] = ~cpol;
        mosi[idx] = b;
        wait_clk(H);
        r = miso[idx];
        sck[idx] = cpol;
        wait_clk(H);
      end
      miso_w[wi][pos] = r;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rdy[i] !== 1'b0 || dout[i] !== 12'h0 || miso[i] !== 1'b0 || ovr[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rx idx=%0d rdy=%b dout=%h miso=%b ovr=%b required 0", i, rdy[i], dout[i], miso[i], ovr[i]);
      end
      n_checks++;
      if (txr[i] !== 1'b1 || und[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tx idx=%0d tx_ready=%b underrun=%b required 1/0", i, txr[i], und[i]);
      end
      n_checks++;
      if (fw[i] !== 8'd0 || fend[i] !== 1'b0 || fpart[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_frame idx=%0d words=%0d end=%b partial=%b required 0", i, fw[i], fend[i], fpart[i]);
      end
    end
  endtask

  task automatic test_mode0_basic;
    int u0, f0;
    got_q.delete();
    got_idx.delete();
    auto_ack = 1'b0;
    tx_push(0, 12'h03C);
    n_checks++;
    if (txr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_tx_ready_drop got=%b required 0", txr[0]);
    end
    u0 = und_cnt[0];
    f0 = fend_cnt[0];
    send_w[0] = 12'h0A5;
    cs_low(0);
    spi_bits(0, 0, 8);
    cs_high(0);
    n_checks++;
    if (rdy[0] !== 1'b1 || dout[0] !== 12'h0A5) begin
      n_fail++;
      $display("FAIL basic_rx ready=%b data=%h required 1/0a5", rdy[0], dout[0]);
    end
    n_checks++;
    if (miso_w[0][7:0] !== 8'h3C) begin
      n_fail++;
      $display("FAIL basic_miso got=%h required 3c", miso_w[0][7:0]);
    end
    n_checks++;
    if (fw[0] !== 8'd1 || fend_cnt[0] - f0 != 1 || last_part[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_frame words=%0d ends=%0d partial=%b required 1/1/0", fw[0], fend_cnt[0] - f0, last_part[0]);
    end
    n_checks++;
    if (und_snap - u0 != 0 || txr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_tx underruns=%0d tx_ready=%b required 0/1", und_snap - u0, txr[0]);
    end
    auto_ack = 1'b1;
    wait_clk(4);
    n_checks++;
    if (rdy[0] !== 1'b0 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL basic_ack ready=%b popped=%0d required 0/1", rdy[0], got_q.size());
    end
  endtask

  task automatic test_modes;
    int u0;
    for (int m = 0; m < 4; m++) begin
      got_q.delete();
      got_idx.delete();
      u0 = und_cnt[m];
      send_w[0] = 12'h081;
      send_w[1] = 12'h07E;
      cs_low(m);
      spi_bits(m, 0, 16);
      cs_high(m);
      n_checks++;
      if (got_q.size() != 2 || got_q[0] !== 12'h081 || got_q[1] !== 12'h07E || got_idx[0] != m) begin
        n_fail++;
        $display("FAIL mode%0d_rx count=%0d first=%h second=%h required 2/081/07e", m, got_q.size(),
                 (got_q.size() > 0) ? got_q[0] : 12'hxxx, (got_q.size() > 1) ? got_q[1] : 12'hxxx);
      end
      n_checks++;
      if (miso_w[0][7:0] !== 8'hFF || miso_w[1][7:0] !== 8'hFF) begin
        n_fail++;
        $display("FAIL mode%0d_miso got=%h,%h required ff,ff", m, miso_w[0][7:0], miso_w[1][7:0]);
      end
      n_checks++;
      if (und_snap - u0 != 2 || fw[m] !== 8'd2) begin
        n_fail++;
        $display("FAIL mode%0d_counts underruns=%0d words=%0d required 2/2", m, und_snap - u0, fw[m]);
      end
    end
  endtask

  task automatic test_lsb12;
    got_q.delete();
    got_idx.delete();
    send_w[0] = 12'h5A3;
    cs_low(4);
    spi_bits(4, 0, 12);
    cs_high(4);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 12'h5A3) begin
      n_fail++;
      $display("FAIL lsb12_rx count=%0d data=%h required 1/5a3", got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'hxxx);
    end
    n_checks++;
    if (miso_w[0] !== 12'hFFF || fw[4] !== 8'd1) begin
      n_fail++;
      $display("FAIL lsb12_tx miso=%h words=%0d required fff/1", miso_w[0], fw[4]);
    end
  endtask

  task automatic test_random;
    int idx, nw, w, u0, exp_und;
    bit pre;
    logic [11:0] mask, pre_w, exp_miso;
    for (int it = 0; it < 8; it++) begin
      idx = $urandom_range(0, 4);
      nw = $urandom_range(1, 3);
      w = width_of(idx);
      mask = (idx == 4) ? 12'hFFF : 12'h0FF;
      pre = $urandom_range(0, 1);
      pre_w = 12'($urandom) & mask;
      for (int j = 0; j < nw; j++) send_w[j] = 12'($urandom) & mask;
      got_q.delete();
      got_idx.delete();
      if (pre) tx_push(idx, pre_w);
      u0 = und_cnt[idx];
      cs_low(idx);
      spi_bits(idx, 0, nw * w);
      cs_high(idx);
      exp_und = (pre ? 0 : 1) + (nw - 1);
      n_checks++;
      if (got_q.size() != nw) begin
        n_fail++;
        $display("FAIL rand_count it=%0d idx=%0d got=%0d required %0d", it, idx, got_q.size(), nw);
      end else begin
        for (int j = 0; j < nw; j++) begin
          n_checks++;
          if (got_q[j] !== send_w[j] || got_idx[j] != idx) begin
            n_fail++;
            $display("FAIL rand_rx it=%0d word=%0d got=%h required %h", it, j, got_q[j], send_w[j]);
          end
        end
      end
      for (int j = 0; j < nw; j++) begin
        exp_miso = (j == 0 && pre) ? pre_w : mask;
        n_checks++;
        if ((miso_w[j] & mask) !== exp_miso) begin
          n_fail++;
          $display("FAIL rand_miso it=%0d word=%0d got=%h required %h", it, j, miso_w[j] & mask, exp_miso);
        end
      end
      n_checks++;
      if (und_snap - u0 != exp_und || fw[idx] !== 8'(nw)) begin
        n_fail++;
        $display("FAIL rand_counts it=%0d underruns=%0d words=%0d required %0d/%0d", it, und_snap - u0, fw[idx], exp_und, nw);
      end
    end
  endtask

  task automatic test_overrun;
    logic [11:0] exp_q [$];
    int exp_ovr, o0;
    exp_ovr = 0;
    got_q.delete();
    got_idx.delete();
    auto_ack = 1'b0;
    for (int j = 0; j < OVR_WORDS; j++) begin
      send_w[j] = 12'($urandom) & 12'h0FF;
      if (exp_q.size() < RX_CAP) exp_q.push_back(send_w[j]);
      else exp_ovr++;
    end
    o0 = ovr_cnt[0];
    cs_low(0);
    spi_bits(0, 0, OVR_WORDS * 8);
    cs_high(0);
    n_checks++;
    if (ovr_cnt[0] - o0 != exp_ovr) begin
      n_fail++;
      $display("FAIL overrun_pulses got=%0d required %0d", ovr_cnt[0] - o0, exp_ovr);
    end
    n_checks++;
    if (rdy[0] !== 1'b1 || dout[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overrun_hold ready=%b data=%h required 1/%h", rdy[0], dout[0], exp_q[0]);
    end
    auto_ack = 1'b1;
    wait_clk(4 * RX_CAP + 6);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL overrun_count got=%0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (got_q[j] !== exp_q[j]) begin
          n_fail++;
          $display("FAIL overrun_order entry=%0d got=%h required %h", j, got_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_partial;
    int f0;
    got_q.delete();
    got_idx.delete();
    f0 = fend_cnt[0];
    send_w[0] = 12'($urandom) & 12'h0FF;
    cs_low(0);
    spi_bits(0, 0, 5);
    cs_high(0);
    n_checks++;
    if (fend_cnt[0] - f0 != 1 || last_part[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_end ends=%0d partial=%b required 1/1", fend_cnt[0] - f0, last_part[0]);
    end
    n_checks++;
    if (got_q.size() != 0 || rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_no_data words=%0d ready=%b required 0/0", got_q.size(), rdy[0]);
    end
    send_w[0] = 12'($urandom) & 12'h0FF;
    cs_low(0);
    spi_bits(0, 0, 8);
    cs_high(0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== send_w[0] || last_part[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_next words=%0d data=%h partial=%b required 1/%h/0", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 12'hxxx, send_w[0], last_part[0]);
    end
  endtask

  task automatic test_reset_midframe;
    int f0;
    got_q.delete();
    got_idx.delete();
    f0 = fend_cnt[2];
    send_w[0] = 12'($urandom) & 12'h0FF;
    cs_low(2);
    tx_push(2, 12'h055);
    spi_bits(2, 0, 3);
    rst_n = 1'b0;
    wait_clk(1);
    n_checks++;
    if (rdy[2] !== 1'b0 || dout[2] !== 12'h0 || miso[2] !== 1'b0 || ovr[2] !== 1'b0 || und[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_rx ready=%b data=%h miso=%b ovr=%b und=%b required 0", rdy[2], dout[2], miso[2], ovr[2], und[2]);
    end
    n_checks++;
    if (txr[2] !== 1'b1 || fw[2] !== 8'd0 || fend[2] !== 1'b0 || fpart[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_tx tx_ready=%b words=%0d end=%b partial=%b required 1/0/0/0", txr[2], fw[2], fend[2], fpart[2]);
    end
    rst_n = 1'b1;
    spi_bits(2, 3, 8);
    cs_high(2);
    n_checks++;
    if (fend_cnt[2] - f0 != 0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_ignored ends=%0d words=%0d required 0/0", fend_cnt[2] - f0, got_q.size());
    end
    send_w[0] = 12'($urandom) & 12'h0FF;
    cs_low(2);
    spi_bits(2, 0, 8);
    cs_high(2);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== send_w[0] || fend_cnt[2] - f0 != 1 || miso_w[0][7:0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL midrst_next words=%0d data=%h ends=%0d miso=%h required 1/%h/1/ff", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 12'hxxx, send_w[0], fend_cnt[2] - f0, miso_w[0][7:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      sck[i] = (i == 2 || i == 3);
      cs[i] = 1'b1;
      mosi[i] = 1'b0;
      txv[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) txd8[i] = 8'h00;
    txd12 = 12'h000;
    rst_n = 1'b0;
    wait_clk(5);
    test_reset;
    rst_n = 1'b1;
    wait_clk(6);
    test_mode0_basic;
    test_modes;
    test_lsb12;
    test_random;
    test_overrun;
    test_partial;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
